// File: rtl/spi_sync_slave_if.sv
// Bus bundle for spi_sync_slave: SPI pins, mode select and the on-chip tx/rx handshake.
interface spi_sync_slave_if #(parameter int WIDTH = 8);
   logic             sclk;
   logic             cs;
   logic             MOSI;
   logic             MISO;
   logic             CPOL;
   logic             CPHA;
   logic [WIDTH-1:0] tx_data;
   logic             tx_load;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;

   modport slave (
      input  sclk, cs, MOSI, CPOL, CPHA, tx_data, tx_load,
      output MISO, tx_ready, rx_data, rx_valid, busy
   );

   modport master (
      output sclk, cs, MOSI, CPOL, CPHA, tx_data, tx_load,
      input  MISO, tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_sync_slave.sv
// SPI target oversampled in the clk domain; all four CPOL/CPHA modes, MSB-first frames.
//   state  | meaning
//   IDLE   | cs deasserted (synced); sclk edges ignored, MISO driven 0
//   ACTIVE | cs asserted; sample/shift on synced sclk edges, back-to-back frames allowed
module spi_sync_slave #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   spi_sync_slave_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d;
   logic                   sclk_s, cs_s, mosi_s;

   state_t           state;
   logic             cpol_l, cpha_l;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] rx_shift, tx_shift, tx_buf;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_pend, rx_valid_q;
   logic             tx_ready_q, miso_q, busy_q;

   logic lead_edge, trail_edge, sample_edge, shift_edge, load_now;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   always_comb begin
      lead_edge   = (sclk_s != cpol_l) && (sclk_d == cpol_l);
      trail_edge  = (sclk_s == cpol_l) && (sclk_d != cpol_l);
      sample_edge = cpha_l ? trail_edge : lead_edge;
      shift_edge  = cpha_l ? lead_edge  : trail_edge;
      // CPHA=0 needs the MSB on MISO before the first edge, so load on select
      load_now    = ((state == IDLE)   && !cs_s && !bus.CPHA) ||
                    ((state == ACTIVE) && !cs_s && shift_edge && (bit_cnt == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cpol_l     <= 1'b0;
         cpha_l     <= 1'b0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         tx_buf     <= '0;
         rx_data_q  <= '0;
         rx_pend    <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
         miso_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= rx_pend;
         rx_pend    <= 1'b0;

         if (bus.tx_load && tx_ready_q) begin
            tx_buf     <= bus.tx_data;
            tx_ready_q <= 1'b0;
         end

         // Empty buffer means underrun: shift out zeros, a same-cycle tx_load fills the buffer
         if (load_now) begin
            if (!tx_ready_q) begin
               tx_shift   <= tx_buf;
               tx_ready_q <= 1'b1;
            end else begin
               tx_shift <= '0;
            end
         end

         case (state)
            IDLE: begin
               miso_q <= 1'b0;
               if (!cs_s) begin
                  state    <= ACTIVE;
                  busy_q   <= 1'b1;
                  cpol_l   <= bus.CPOL;
                  cpha_l   <= bus.CPHA;
                  bit_cnt  <= '0;
                  rx_shift <= '0;
               end
            end
            ACTIVE: begin
               miso_q <= tx_shift[WIDTH-1];
               if (cs_s) begin
                  state    <= IDLE;
                  busy_q   <= 1'b0;
                  miso_q   <= 1'b0;
                  bit_cnt  <= '0;
                  rx_shift <= '0;
                  tx_shift <= '0;
               end else if (sample_edge) begin
                  rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                  if (bit_cnt == CW'(WIDTH-1)) begin
                     bit_cnt   <= '0;
                     rx_data_q <= {rx_shift[WIDTH-2:0], mosi_s};
                     rx_pend   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (shift_edge && (bit_cnt != '0)) begin
                  tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.MISO     = miso_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_sync_slave.sv
// Bench for spi_sync_slave: SPI master model plus rx scoreboard queue.
module tb_spi_sync_slave;
   localparam int HALF = 6;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] exp_rx[$];
   logic       prev_rv = 1'b0;
   logic [7:0] mi;

   spi_sync_slave_if #(.WIDTH(8)) bus ();

   spi_sync_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && bus.rx_valid) begin
         if (exp_rx.size() == 0) chk("rx_spurious", 32'd1, 32'd0);
         else                    chk("rx_word", bus.rx_data, exp_rx.pop_front());
         chk("rx_valid_1clk", prev_rv, 1'b0);
      end
      prev_rv = bus.rx_valid;
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load(input logic [7:0] v);
      @(negedge clk);
      bus.tx_data = v;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
   endtask

   task automatic cs_begin(input logic pol, input logic pha);
      @(negedge clk);
      bus.CPOL = pol;
      bus.CPHA = pha;
      bus.sclk = pol;
      wclk(4);
      bus.cs = 1'b0;
      wclk(8);
      chk("busy_active", bus.busy, 1'b1);
   endtask

   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] m_in);
      m_in = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!bus.CPHA) begin
            bus.MOSI = mo[7-i];
            wclk(HALF);
            bus.sclk = ~bus.CPOL;
            m_in = {m_in[6:0], bus.MISO};
            wclk(HALF);
            bus.sclk = bus.CPOL;
         end else begin
            bus.sclk = ~bus.CPOL;
            bus.MOSI = mo[7-i];
            wclk(HALF);
            bus.sclk = bus.CPOL;
            m_in = {m_in[6:0], bus.MISO};
            wclk(HALF);
         end
      end
   endtask

   task automatic cs_end();
      wclk(HALF);
      bus.cs = 1'b1;
      wclk(8);
      chk("busy_idle", bus.busy, 1'b0);
      chk("miso_idle", bus.MISO, 1'b0);
   endtask

   initial begin
      bus.sclk = 1'b0; bus.cs = 1'b1; bus.MOSI = 1'b0;
      bus.CPOL = 1'b0; bus.CPHA = 1'b0;
      bus.tx_data = '0; bus.tx_load = 1'b0;
      reset = 1'b1;
      wclk(3);
      chk("rst_miso",     bus.MISO,     1'b0);
      chk("rst_tx_ready", bus.tx_ready, 1'b1);
      chk("rst_rx_data",  bus.rx_data,  8'h00);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_busy",     bus.busy,     1'b0);
      reset = 1'b0;
      wclk(4);

      // mode 0
      pulse_load(8'hA5);
      chk("tx_ready_fall", bus.tx_ready, 1'b0);
      exp_rx.push_back(8'h3C);
      cs_begin(1'b0, 1'b0);
      xfer(8'h3C, 8, mi);
      chk("mode0_miso_word", mi, 8'hA5);
      cs_end();

      // modes 1..3
      for (int m = 1; m < 4; m++) begin
         pulse_load(8'h81);
         exp_rx.push_back(8'h7E);
         cs_begin(m[1], m[0]);
         xfer(8'h7E, 8, mi);
         chk("modeN_miso_word", mi, 8'h81);
         cs_end();
      end

      // back-to-back, mode 0
      pulse_load(8'h11);
      exp_rx.push_back(8'hF0);
      exp_rx.push_back(8'h0F);
      cs_begin(1'b0, 1'b0);
      chk("b2b_tx_ready_rise", bus.tx_ready, 1'b1);
      pulse_load(8'h22);
      xfer(8'hF0, 8, mi);
      chk("b2b_first_word", mi, 8'h11);
      xfer(8'h0F, 8, mi);
      chk("b2b_second_word", mi, 8'h22);
      cs_end();

      // underrun, mode 3
      exp_rx.push_back(8'h55);
      cs_begin(1'b1, 1'b1);
      xfer(8'h55, 8, mi);
      chk("underrun_word", mi, 8'h00);
      chk("underrun_tx_ready", bus.tx_ready, 1'b1);
      cs_end();

      // abort after 5 bits, then a clean frame
      pulse_load(8'h99);
      cs_begin(1'b0, 1'b0);
      xfer(8'hE7, 5, mi);
      cs_end();
      chk("abort_rx_data", bus.rx_data, 8'h55);
      pulse_load(8'hC3);
      exp_rx.push_back(8'h5A);
      cs_begin(1'b0, 1'b0);
      xfer(8'h5A, 8, mi);
      chk("post_abort_word", mi, 8'hC3);
      cs_end();

      // reset mid-frame
      pulse_load(8'h77);
      cs_begin(1'b0, 1'b0);
      xfer(8'hFF, 3, mi);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_miso",     bus.MISO,     1'b0);
      chk("midrst_tx_ready", bus.tx_ready, 1'b1);
      chk("midrst_rx_data",  bus.rx_data,  8'h00);
      chk("midrst_rx_valid", bus.rx_valid, 1'b0);
      chk("midrst_busy",     bus.busy,     1'b0);
      bus.cs = 1'b1;
      bus.sclk = 1'b0;
      wclk(3);
      reset = 1'b0;
      wclk(4);
      chk("post_rst_idle", bus.busy, 1'b0);

      // load while full is ignored
      pulse_load(8'h33);
      pulse_load(8'h44);
      chk("ignored_load_ready", bus.tx_ready, 1'b0);
      exp_rx.push_back(8'h96);
      cs_begin(1'b0, 1'b0);
      xfer(8'h96, 8, mi);
      chk("held_first_word", mi, 8'h33);
      cs_end();

      wclk(10);
      chk("rx_queue_drained", exp_rx.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spi_sync_slave.md
# spi_sync_slave

SPI target that runs entirely in the system `clk` domain, oversampling `sclk`, `cs` and `MOSI` through synchronizers instead of clocking on `sclk`. It exchanges WIDTH-bit frames MSB-first with the existing `master` in all four CPOL/CPHA modes, and supports back-to-back frames while `cs` stays low. A buffered transmit handshake and a receive-valid pulse connect it to on-chip logic. It is a drop-in peer for `slave` on the shared MOSI/MISO/sclk bus.

## Interface
- WIDTH, 8, frame length in bits
- SYNC_STAGES, 2, synchronizer depth for sclk/cs/MOSI (≥2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- CPOL  in  1  sclk idle level; latched on cs falling
- CPHA  in  1  0: sample on leading edge, 1: sample on trailing edge; latched on cs falling
- sclk  in  1  serial clock from master (asynchronous)
- cs  in  1  chip select, active low (asynchronous)
- MOSI  in  1  serial data in
- MISO  out  1  serial data out; 0 when not selected
- tx_data  in  WIDTH  next word to transmit
- tx_load  in  1  write tx_data into tx buffer when tx_ready=1
- tx_ready  out  1  tx buffer empty
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  one-cycle pulse: rx_data updated
- busy  out  1  frame session active (state ACTIVE)

## Operation
- Reset: MISO=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, bit_cnt=0, shift regs=0, cs sync flops=1, sclk/MOSI sync flops=0, state IDLE.
- sclk, cs, MOSI each pass through SYNC_STAGES flops; one extra flop of synchronized sclk gives edge detect.
- Leading edge = synced sclk leaves CPOL level; trailing = returns to CPOL. Sample edge = leading if CPHA=0, else trailing; shift edge = the other.
- States: IDLE (cs_s=1) -> ACTIVE on cs_s falling; ACTIVE -> IDLE on cs_s rising. sclk edges in IDLE ignored.
- On IDLE->ACTIVE: latch CPOL/CPHA, bit_cnt=0; if CPHA=0, load tx_shift (see load rule).
- Sample edge: rx_shift <= {rx_shift[WIDTH-2:0], MOSI_s}; bit_cnt++. When bit_cnt was WIDTH-1: bit_cnt wraps to 0, rx_data <= completed word, rx_valid=1 next cycle.
- Shift edge: if bit_cnt==0, load tx_shift; else tx_shift <<= 1.
- Load rule: if tx buffer full, tx_shift <= buffer, buffer empties (tx_ready=1 next cycle); if empty, tx_shift <= 0 (underrun sends zeros).
- MISO = tx_shift[WIDTH-1] in ACTIVE, 0 in IDLE.
- tx_load with tx_ready=1 captures tx_data; with tx_ready=0 ignored. Simultaneous tx_load and consumption of an empty buffer: the word loads the buffer, not tx_shift (zeros sent).
- cs rising mid-frame: abort; partial rx discarded, no rx_valid, bit_cnt=0, tx_shift discarded; tx buffer unaffected unless already consumed.
- Back-to-back frames: cs held low, next frame starts on the next sample edge; reload occurs on the shift edge with bit_cnt==0.

## Timing
- Input-to-action latency: SYNC_STAGES+1 clk from a pin change to its edge/state effect.
- sclk high and low phases must each be ≥ SYNC_STAGES+2 clk; sclk period ≥ 2·(SYNC_STAGES+2) clk (8 clk at default).
- cs falling to first sclk edge ≥ SYNC_STAGES+2 clk so MISO MSB is valid (CPHA=0).
- MISO updates SYNC_STAGES+2 clk after the pin-level shift edge.
- rx_valid asserts SYNC_STAGES+2 clk after the pin-level final sample edge, for exactly 1 clk.
- tx_ready falls the clk after an accepted tx_load; rises the clk after the buffer is consumed.
- Reset mid-frame: immediate return to reset values; state IDLE until next cs falling.

## Test plan
- Mode 0 (CPOL=0,CPHA=0), tx_load 0xA5, master sends 0x3C -> rx_data=0x3C with single rx_valid pulse; master receives 0xA5.
- Modes 1,2,3 each: slave 0x81, master 0x7E -> rx_data=0x7E, master gets 0x81; idle MISO=0.
- Back-to-back: buffer 0x11, refilled with 0x22 after tx_ready rises, two frames with cs low (master 0xF0,0x0F) -> two rx_valid pulses, rx_data 0xF0 then 0x0F; master gets 0x11,0x22.
- Underrun: no tx_load, one frame -> master receives 0x00, tx_ready stays 1, rx still valid.
- Abort: cs rises after 5 bits -> no rx_valid, rx_data unchanged, busy=0; next full frame 0x5A received correctly.
- Reset asserted mid-frame -> all outputs at reset values within 1 clk; tx_load while tx_ready=0 ignored (buffer holds first word).
